// File: rtl/hpu_pkg.sv
// ---------------------------------------------------------------------------
// hpu_pkg
// Shared definitions for the HPU CSR fabric as seen by the NDMA CSR slave:
//   - CSR_ADDR_NDMA_* register addresses (byte addresses, word stride)
//   - ndma_cmd_e    : command / completion type encoding
//   - csr_bus_req_t : broadcast request from the CSR hub (read + write)
//   - csr_bus_rsp_t : read data returned on the lcarb response bus
//   - ndma_cmd_t    : bundled descriptor as presented to the NDMA engine
//   - ndma_state_e  : launch FSM states
// ---------------------------------------------------------------------------
package hpu_pkg;

    localparam int CSR_AW = 12;
    localparam int CSR_DW = 32;

    typedef logic [CSR_AW-1:0] csr_addr_t;

    localparam csr_addr_t CSR_ADDR_NDMA_CTRL      = 12'h400;
    localparam csr_addr_t CSR_ADDR_NDMA_STATUS    = 12'h404;
    localparam csr_addr_t CSR_ADDR_NDMA_LCADDR    = 12'h408;
    localparam csr_addr_t CSR_ADDR_NDMA_RTADDR    = 12'h40C;
    localparam csr_addr_t CSR_ADDR_NDMA_SIZE      = 12'h410;
    localparam csr_addr_t CSR_ADDR_NDMA_DESTXY    = 12'h414;
    localparam csr_addr_t CSR_ADDR_NDMA_WR_DONE   = 12'h418;
    localparam csr_addr_t CSR_ADDR_NDMA_RD_DONE   = 12'h41C;
    localparam csr_addr_t CSR_ADDR_NDMA_SWAP_DONE = 12'h420;
    localparam csr_addr_t CSR_ADDR_NDMA_WR_MASK   = 12'h424;
    localparam csr_addr_t CSR_ADDR_NDMA_RD_MASK   = 12'h428;
    localparam csr_addr_t CSR_ADDR_NDMA_SWAP_MASK = 12'h42C;

    // Default descriptor field widths used by the engine-side bundle.
    localparam int NDMA_SIZE_W = 20;
    localparam int NDMA_XY_W   = 2;

    typedef enum logic [1:0] {
        NDMA_CMD_NONE = 2'd0,
        NDMA_CMD_WR   = 2'd1,
        NDMA_CMD_RD   = 2'd2,
        NDMA_CMD_SWAP = 2'd3
    } ndma_cmd_e;

    typedef enum logic [1:0] {
        NDMA_ST_IDLE = 2'd0,
        NDMA_ST_REQ  = 2'd1,
        NDMA_ST_WAIT = 2'd2
    } ndma_state_e;

    typedef struct packed {
        csr_addr_t          raddr;
        logic               wr_en;
        csr_addr_t          waddr;
        logic [CSR_DW-1:0]  wdata;
    } csr_bus_req_t;

    typedef struct packed {
        logic [CSR_DW-1:0]  rdata;
    } csr_bus_rsp_t;

    typedef struct packed {
        ndma_cmd_e               cmd_type;
        logic [31:0]             lcaddr;
        logic [31:0]             rtaddr;
        logic [NDMA_SIZE_W-1:0]  size;
        logic [NDMA_XY_W-1:0]    destx;
        logic [NDMA_XY_W-1:0]    desty;
    } ndma_cmd_t;

endpackage

// File: rtl/hpu_ndma_csr_done_cnt.sv
// ---------------------------------------------------------------------------
// hpu_ndma_done_cnt
// Completion counter with CSR load and single-step increment.
// A load and an increment in the same cycle yield load_val_i + 1, so a
// software write never swallows a completion that lands on the same edge.
// Wraps naturally at 2^W.
// Ports:
//   clk_i       core clock
//   rst_i       asynchronous active-low reset
//   load_i      CSR write strobe for this counter
//   load_val_i  value written by software
//   inc_i       completion pulse of this counter's type
//   cnt_o       current count
// ---------------------------------------------------------------------------
module hpu_ndma_done_cnt #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    // Load first, then increment on top of whatever the base value is.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end
        if (inc_i) begin
            cnt_d = cnt_d + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hpu_ndma_csr.sv
// ---------------------------------------------------------------------------
// hpu_ndma_csr
// CSR slave for the NDMA register group in the lcarb domain. Holds the DMA
// descriptor, launches one command at a time to the NDMA engine over a
// valid/ready handshake, counts completions per type and drives a masked
// level interrupt.
// Ports:
//   clk_i / rst_i        core clock, asynchronous active-low reset
//   csr_bus_req_i        broadcast CSR request (raddr, wr_en, waddr, wdata)
//   csr_bus_rsp_o        registered read data (one cycle latency)
//   ndma_cmd_vld_o/rdy_i command handshake to the engine
//   ndma_cmd_type_o, ndma_lcaddr_o, ndma_rtaddr_o, ndma_size_o,
//   ndma_destx_o, ndma_desty_o   command fields, stable while valid
//   ndma_done_i / ndma_done_type_i  one-cycle completion pulse and its type
//   ndma_irq_o           registered interrupt level
// ---------------------------------------------------------------------------
module hpu_ndma_csr
    import hpu_pkg::*;
#(
    parameter int SIZE_W = 20,
    parameter int DONE_W = 16,
    parameter int XY_W   = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  csr_bus_req_t       csr_bus_req_i,
    output csr_bus_rsp_t       csr_bus_rsp_o,
    output logic               ndma_cmd_vld_o,
    input  logic               ndma_cmd_rdy_i,
    output logic [1:0]         ndma_cmd_type_o,
    output logic [31:0]        ndma_lcaddr_o,
    output logic [31:0]        ndma_rtaddr_o,
    output logic [SIZE_W-1:0]  ndma_size_o,
    output logic [XY_W-1:0]    ndma_destx_o,
    output logic [XY_W-1:0]    ndma_desty_o,
    input  logic               ndma_done_i,
    input  logic [1:0]         ndma_done_type_i,
    output logic               ndma_irq_o
);

    ndma_state_e        state_q, state_d;
    logic               busy;

    logic [1:0]         ctrl_q, ctrl_d;
    logic               err_q, err_d;
    logic [31:0]        lcaddr_q, lcaddr_d;
    logic [31:0]        rtaddr_q, rtaddr_d;
    logic [SIZE_W-1:0]  size_q, size_d;
    logic [XY_W-1:0]    destx_q, destx_d;
    logic [XY_W-1:0]    desty_q, desty_d;
    logic               wr_mask_q, wr_mask_d;
    logic               rd_mask_q, rd_mask_d;
    logic               swap_mask_q, swap_mask_d;

    ndma_cmd_e          cmd_type_q, cmd_type_d;
    logic [31:0]        cmd_lcaddr_q, cmd_lcaddr_d;
    logic [31:0]        cmd_rtaddr_q, cmd_rtaddr_d;
    logic [SIZE_W-1:0]  cmd_size_q, cmd_size_d;
    logic [XY_W-1:0]    cmd_destx_q, cmd_destx_d;
    logic [XY_W-1:0]    cmd_desty_q, cmd_desty_d;

    logic [31:0]        rdata_q, rdata_d;
    logic               irq_q, irq_d;

    logic [DONE_W-1:0]  wr_cnt, rd_cnt, swap_cnt;

    logic               wr_ctrl, wr_status, wr_lcaddr, wr_rtaddr, wr_size, wr_destxy;
    logic               wr_wr_done, wr_rd_done, wr_swap_done;
    logic               wr_wr_mask, wr_rd_mask, wr_swap_mask;
    logic               desc_wr;
    logic               cmd_nonzero;
    logic               launch;
    logic [31:0]        wdata;
    logic               unused_wdata;

    assign wdata = csr_bus_req_i.wdata;

    // Upper wdata bits are don't-care for most registers.
    assign unused_wdata = ^wdata;

    // Write strobe decode.
    always_comb begin
        wr_ctrl      = csr_bus_req_i.wr_en && (csr_bus_req_i.waddr == CSR_ADDR_NDMA_CTRL);
        wr_status    = csr_bus_req_i.wr_en && (csr_bus_req_i.waddr == CSR_ADDR_NDMA_STATUS);
        wr_lcaddr    = csr_bus_req_i.wr_en && (csr_bus_req_i.waddr == CSR_ADDR_NDMA_LCADDR);
        wr_rtaddr    = csr_bus_req_i.wr_en && (csr_bus_req_i.waddr == CSR_ADDR_NDMA_RTADDR);
        wr_size      = csr_bus_req_i.wr_en && (csr_bus_req_i.waddr == CSR_ADDR_NDMA_SIZE);
        wr_destxy    = csr_bus_req_i.wr_en && (csr_bus_req_i.waddr == CSR_ADDR_NDMA_DESTXY);
        wr_wr_done   = csr_bus_req_i.wr_en && (csr_bus_req_i.waddr == CSR_ADDR_NDMA_WR_DONE);
        wr_rd_done   = csr_bus_req_i.wr_en && (csr_bus_req_i.waddr == CSR_ADDR_NDMA_RD_DONE);
        wr_swap_done = csr_bus_req_i.wr_en && (csr_bus_req_i.waddr == CSR_ADDR_NDMA_SWAP_DONE);
        wr_wr_mask   = csr_bus_req_i.wr_en && (csr_bus_req_i.waddr == CSR_ADDR_NDMA_WR_MASK);
        wr_rd_mask   = csr_bus_req_i.wr_en && (csr_bus_req_i.waddr == CSR_ADDR_NDMA_RD_MASK);
        wr_swap_mask = csr_bus_req_i.wr_en && (csr_bus_req_i.waddr == CSR_ADDR_NDMA_SWAP_MASK);
        desc_wr      = wr_lcaddr || wr_rtaddr || wr_size || wr_destxy;
        cmd_nonzero  = (wdata[1:0] != 2'd0);
        launch       = wr_ctrl && cmd_nonzero && (size_q != '0);
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= NDMA_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: one command in flight; REQ waits for the handshake,
    // WAIT waits for the engine's completion pulse.
    always_comb begin
        state_d = state_q;
        case (state_q)
            NDMA_ST_IDLE: if (launch)         state_d = NDMA_ST_REQ;
            NDMA_ST_REQ:  if (ndma_cmd_rdy_i) state_d = NDMA_ST_WAIT;
            NDMA_ST_WAIT: if (ndma_done_i)    state_d = NDMA_ST_IDLE;
            default:                          state_d = NDMA_ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        ndma_cmd_vld_o = (state_q == NDMA_ST_REQ);
        busy           = (state_q != NDMA_ST_IDLE);
    end

    // Software-visible registers. The descriptor and CTRL are frozen while a
    // command is outstanding; any attempt to touch them flags err, as does a
    // launch attempt with a zero size.
    always_comb begin
        ctrl_d      = ctrl_q;
        err_d       = err_q;
        lcaddr_d    = lcaddr_q;
        rtaddr_d    = rtaddr_q;
        size_d      = size_q;
        destx_d     = destx_q;
        desty_d     = desty_q;
        wr_mask_d   = wr_mask_q;
        rd_mask_d   = rd_mask_q;
        swap_mask_d = swap_mask_q;

        if (!busy) begin
            if (wr_ctrl)   ctrl_d   = wdata[1:0];
            if (wr_lcaddr) lcaddr_d = wdata;
            if (wr_rtaddr) rtaddr_d = wdata;
            if (wr_size)   size_d   = wdata[SIZE_W-1:0];
            if (wr_destxy) begin
                destx_d = wdata[XY_W-1:0];
                desty_d = wdata[2*XY_W-1:XY_W];
            end
        end

        if (busy && (desc_wr || wr_ctrl)) begin
            err_d = 1'b1;
        end else if (!busy && wr_ctrl && cmd_nonzero && (size_q == '0)) begin
            err_d = 1'b1;
        end else if (wr_status && wdata[1]) begin
            err_d = 1'b0;
        end

        if (wr_wr_mask)   wr_mask_d   = wdata[0];
        if (wr_rd_mask)   rd_mask_d   = wdata[0];
        if (wr_swap_mask) swap_mask_d = wdata[0];
    end

    // Command snapshot: captured at launch so the engine sees stable fields
    // for as long as valid is high.
    always_comb begin
        cmd_type_d   = cmd_type_q;
        cmd_lcaddr_d = cmd_lcaddr_q;
        cmd_rtaddr_d = cmd_rtaddr_q;
        cmd_size_d   = cmd_size_q;
        cmd_destx_d  = cmd_destx_q;
        cmd_desty_d  = cmd_desty_q;
        if ((state_q == NDMA_ST_IDLE) && launch) begin
            cmd_type_d   = ndma_cmd_e'(wdata[1:0]);
            cmd_lcaddr_d = lcaddr_q;
            cmd_rtaddr_d = rtaddr_q;
            cmd_size_d   = size_q;
            cmd_destx_d  = destx_q;
            cmd_desty_d  = desty_q;
        end
    end

    // Read mux, registered below; unmapped addresses read as zero.
    always_comb begin
        rdata_d = '0;
        case (csr_bus_req_i.raddr)
            CSR_ADDR_NDMA_CTRL:      rdata_d = {30'd0, ctrl_q};
            CSR_ADDR_NDMA_STATUS:    rdata_d = {30'd0, err_q, busy};
            CSR_ADDR_NDMA_LCADDR:    rdata_d = lcaddr_q;
            CSR_ADDR_NDMA_RTADDR:    rdata_d = rtaddr_q;
            CSR_ADDR_NDMA_SIZE:      rdata_d = 32'(size_q);
            CSR_ADDR_NDMA_DESTXY:    rdata_d = 32'({desty_q, destx_q});
            CSR_ADDR_NDMA_WR_DONE:   rdata_d = 32'(wr_cnt);
            CSR_ADDR_NDMA_RD_DONE:   rdata_d = 32'(rd_cnt);
            CSR_ADDR_NDMA_SWAP_DONE: rdata_d = 32'(swap_cnt);
            CSR_ADDR_NDMA_WR_MASK:   rdata_d = {31'd0, wr_mask_q};
            CSR_ADDR_NDMA_RD_MASK:   rdata_d = {31'd0, rd_mask_q};
            CSR_ADDR_NDMA_SWAP_MASK: rdata_d = {31'd0, swap_mask_q};
            default:                 rdata_d = '0;
        endcase
    end

    // Interrupt follows the registered counters, so it lags a count change
    // by one cycle.
    always_comb begin
        irq_d = ((wr_cnt   != '0) && wr_mask_q)
             || ((rd_cnt   != '0) && rd_mask_q)
             || ((swap_cnt != '0) && swap_mask_q);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ctrl_q       <= '0;
            err_q        <= 1'b0;
            lcaddr_q     <= '0;
            rtaddr_q     <= '0;
            size_q       <= '0;
            destx_q      <= '0;
            desty_q      <= '0;
            wr_mask_q    <= 1'b0;
            rd_mask_q    <= 1'b0;
            swap_mask_q  <= 1'b0;
            cmd_type_q   <= NDMA_CMD_NONE;
            cmd_lcaddr_q <= '0;
            cmd_rtaddr_q <= '0;
            cmd_size_q   <= '0;
            cmd_destx_q  <= '0;
            cmd_desty_q  <= '0;
            rdata_q      <= '0;
            irq_q        <= 1'b0;
        end else begin
            ctrl_q       <= ctrl_d;
            err_q        <= err_d;
            lcaddr_q     <= lcaddr_d;
            rtaddr_q     <= rtaddr_d;
            size_q       <= size_d;
            destx_q      <= destx_d;
            desty_q      <= desty_d;
            wr_mask_q    <= wr_mask_d;
            rd_mask_q    <= rd_mask_d;
            swap_mask_q  <= swap_mask_d;
            cmd_type_q   <= cmd_type_d;
            cmd_lcaddr_q <= cmd_lcaddr_d;
            cmd_rtaddr_q <= cmd_rtaddr_d;
            cmd_size_q   <= cmd_size_d;
            cmd_destx_q  <= cmd_destx_d;
            cmd_desty_q  <= cmd_desty_d;
            rdata_q      <= rdata_d;
            irq_q        <= irq_d;
        end
    end

    // Per-type completion counters; done_type NONE matches no counter.
    hpu_ndma_done_cnt #(.W(DONE_W)) u_wr_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (wr_wr_done),
        .load_val_i (wdata[DONE_W-1:0]),
        .inc_i      (ndma_done_i && (ndma_done_type_i == NDMA_CMD_WR)),
        .cnt_o      (wr_cnt)
    );

    hpu_ndma_done_cnt #(.W(DONE_W)) u_rd_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (wr_rd_done),
        .load_val_i (wdata[DONE_W-1:0]),
        .inc_i      (ndma_done_i && (ndma_done_type_i == NDMA_CMD_RD)),
        .cnt_o      (rd_cnt)
    );

    hpu_ndma_done_cnt #(.W(DONE_W)) u_swap_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (wr_swap_done),
        .load_val_i (wdata[DONE_W-1:0]),
        .inc_i      (ndma_done_i && (ndma_done_type_i == NDMA_CMD_SWAP)),
        .cnt_o      (swap_cnt)
    );

    assign csr_bus_rsp_o.rdata = rdata_q;
    assign ndma_cmd_type_o     = cmd_type_q;
    assign ndma_lcaddr_o       = cmd_lcaddr_q;
    assign ndma_rtaddr_o       = cmd_rtaddr_q;
    assign ndma_size_o         = cmd_size_q;
    assign ndma_destx_o        = cmd_destx_q;
    assign ndma_desty_o        = cmd_desty_q;
    assign ndma_irq_o          = irq_q;

endmodule

// File: tb/tb_hpu_ndma_csr.sv
// ---------------------------------------------------------------------------
// tb_hpu_ndma_csr
// Directed bench for the NDMA CSR slave. Inputs change 1 ns after the rising
// edge and outputs are sampled there too, well away from the active edge.
// ---------------------------------------------------------------------------
module tb_hpu_ndma_csr;
    import hpu_pkg::*;

    logic          clk_i = 1'b0;
    logic          rst_i;
    csr_bus_req_t  req;
    csr_bus_rsp_t  rsp;
    logic          vld;
    logic          rdy;
    logic [1:0]    cmd_type;
    logic [31:0]   lcaddr;
    logic [31:0]   rtaddr;
    logic [19:0]   size;
    logic [1:0]    destx;
    logic [1:0]    desty;
    logic          done;
    logic [1:0]    done_type;
    logic          irq;

    int checks = 0;
    int errors = 0;

    csr_addr_t all_addrs [12] = '{
        CSR_ADDR_NDMA_CTRL, CSR_ADDR_NDMA_STATUS, CSR_ADDR_NDMA_LCADDR,
        CSR_ADDR_NDMA_RTADDR, CSR_ADDR_NDMA_SIZE, CSR_ADDR_NDMA_DESTXY,
        CSR_ADDR_NDMA_WR_DONE, CSR_ADDR_NDMA_RD_DONE, CSR_ADDR_NDMA_SWAP_DONE,
        CSR_ADDR_NDMA_WR_MASK, CSR_ADDR_NDMA_RD_MASK, CSR_ADDR_NDMA_SWAP_MASK
    };

    always #5 clk_i = ~clk_i;

    hpu_ndma_csr #(.SIZE_W(20), .DONE_W(16), .XY_W(2)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .csr_bus_req_i    (req),
        .csr_bus_rsp_o    (rsp),
        .ndma_cmd_vld_o   (vld),
        .ndma_cmd_rdy_i   (rdy),
        .ndma_cmd_type_o  (cmd_type),
        .ndma_lcaddr_o    (lcaddr),
        .ndma_rtaddr_o    (rtaddr),
        .ndma_size_o      (size),
        .ndma_destx_o     (destx),
        .ndma_desty_o     (desty),
        .ndma_done_i      (done),
        .ndma_done_type_i (done_type),
        .ndma_irq_o       (irq)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic csr_write(input csr_addr_t a, input logic [31:0] d);
        req.wr_en = 1'b1;
        req.waddr = a;
        req.wdata = d;
        tick();
        req.wr_en = 1'b0;
        req.waddr = '0;
        req.wdata = '0;
    endtask

    task automatic csr_read(input csr_addr_t a, output logic [31:0] d);
        req.raddr = a;
        tick();
        d = rsp.rdata;
    endtask

    task automatic done_pulse(input logic [1:0] t);
        done      = 1'b1;
        done_type = t;
        tick();
        done      = 1'b0;
        done_type = 2'd0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst_i = 1'b0;
        req   = '0;
        rdy   = 1'b0;
        done  = 1'b0;
        done_type = 2'd0;
        repeat (3) tick();
        checks++;
        if (vld !== 1'b0) begin errors++; $display("[TB] FAIL reset_vld got %b expected 0", vld); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq got %b expected 0", irq); end
        checks++;
        if (rsp.rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata got %h expected 0", rsp.rdata); end
        rst_i = 1'b1;
        tick();
        csr_read(CSR_ADDR_NDMA_STATUS, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("[TB] FAIL reset_status got %h expected 0", d); end
    endtask

    task automatic test_read_latency();
        csr_write(CSR_ADDR_NDMA_LCADDR, 32'h8000_1000);
        csr_write(CSR_ADDR_NDMA_RTADDR, 32'h0004_0000);
        req.raddr = CSR_ADDR_NDMA_LCADDR;
        #1;
        checks++;
        if (rsp.rdata !== 32'h0) begin errors++; $display("[TB] FAIL rd_not_early got %h expected 0", rsp.rdata); end
        tick();
        checks++;
        if (rsp.rdata !== 32'h8000_1000) begin errors++; $display("[TB] FAIL rd_lcaddr got %h expected 80001000", rsp.rdata); end
        req.raddr = CSR_ADDR_NDMA_RTADDR;
        #1;
        checks++;
        if (rsp.rdata !== 32'h8000_1000) begin errors++; $display("[TB] FAIL rd_hold got %h expected 80001000", rsp.rdata); end
        tick();
        checks++;
        if (rsp.rdata !== 32'h0004_0000) begin errors++; $display("[TB] FAIL rd_rtaddr got %h expected 00040000", rsp.rdata); end
        req.raddr = 12'h7C0;
        tick();
        checks++;
        if (rsp.rdata !== 32'h0) begin errors++; $display("[TB] FAIL rd_unmapped got %h expected 0", rsp.rdata); end
    endtask

    task automatic test_cmd_launch();
        csr_write(CSR_ADDR_NDMA_SIZE, 32'h40);
        csr_write(CSR_ADDR_NDMA_DESTXY, 32'hB);
        rdy = 1'b0;
        req.raddr = CSR_ADDR_NDMA_STATUS;
        csr_write(CSR_ADDR_NDMA_CTRL, 32'h1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (vld !== 1'b1) begin errors++; $display("[TB] FAIL launch_vld[%0d] got %b expected 1", i, vld); end
            checks++;
            if ({cmd_type, lcaddr, rtaddr, size, destx, desty} !== {2'd1, 32'h8000_1000, 32'h0004_0000, 20'h40, 2'd3, 2'd2}) begin
                errors++;
                $display("[TB] FAIL launch_fields[%0d] got %h %h %h %h %h %h expected 1 80001000 00040000 40 3 2",
                         i, cmd_type, lcaddr, rtaddr, size, destx, desty);
            end
            if (i >= 1) begin
                checks++;
                if (rsp.rdata !== 32'h1) begin errors++; $display("[TB] FAIL launch_status[%0d] got %h expected 1", i, rsp.rdata); end
            end
            if (i == 3) rdy = 1'b1;
            tick();
        end
        rdy = 1'b0;
        checks++;
        if (vld !== 1'b0) begin errors++; $display("[TB] FAIL accept_vld_drop got %b expected 0", vld); end
        tick();
        checks++;
        if (rsp.rdata !== 32'h1) begin errors++; $display("[TB] FAIL wait_status got %h expected 1", rsp.rdata); end
    endtask

    task automatic test_completion();
        logic [31:0] d;
        csr_write(CSR_ADDR_NDMA_WR_MASK, 32'h1);
        done_pulse(2'd1);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_early got %b expected 0", irq); end
        tick();
        checks++;
        if (irq !== 1'b1) begin errors++; $display("[TB] FAIL irq_rise got %b expected 1", irq); end
        csr_read(CSR_ADDR_NDMA_WR_DONE, d);
        checks++;
        if (d !== 32'h1) begin errors++; $display("[TB] FAIL wr_done_cnt got %h expected 1", d); end
        csr_read(CSR_ADDR_NDMA_STATUS, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("[TB] FAIL idle_status got %h expected 0", d); end
        csr_write(CSR_ADDR_NDMA_WR_DONE, 32'h0);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("[TB] FAIL irq_hold got %b expected 1", irq); end
        tick();
        checks++;
        if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_fall got %b expected 0", irq); end
    endtask

    task automatic test_reject();
        logic [31:0] d;
        rdy = 1'b1;
        csr_write(CSR_ADDR_NDMA_CTRL, 32'h1);
        checks++;
        if (vld !== 1'b1) begin errors++; $display("[TB] FAIL rej_launch_vld got %b expected 1", vld); end
        tick();
        rdy = 1'b0;
        csr_write(CSR_ADDR_NDMA_CTRL, 32'h2);
        checks++;
        if (vld !== 1'b0) begin errors++; $display("[TB] FAIL rej_busy_vld got %b expected 0", vld); end
        tick();
        checks++;
        if (vld !== 1'b0) begin errors++; $display("[TB] FAIL rej_busy_vld2 got %b expected 0", vld); end
        csr_read(CSR_ADDR_NDMA_STATUS, d);
        checks++;
        if (d !== 32'h3) begin errors++; $display("[TB] FAIL rej_status got %h expected 3", d); end
        csr_write(CSR_ADDR_NDMA_LCADDR, 32'hDEAD_BEEF);
        csr_read(CSR_ADDR_NDMA_LCADDR, d);
        checks++;
        if (d !== 32'h8000_1000) begin errors++; $display("[TB] FAIL rej_desc_hold got %h expected 80001000", d); end
        csr_write(CSR_ADDR_NDMA_STATUS, 32'h2);
        csr_read(CSR_ADDR_NDMA_STATUS, d);
        checks++;
        if (d !== 32'h1) begin errors++; $display("[TB] FAIL err_clear got %h expected 1", d); end
        csr_read(CSR_ADDR_NDMA_CTRL, d);
        checks++;
        if (d !== 32'h1) begin errors++; $display("[TB] FAIL ctrl_hold got %h expected 1", d); end
        done_pulse(2'd1);
        csr_read(CSR_ADDR_NDMA_STATUS, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("[TB] FAIL rej_idle got %h expected 0", d); end
        csr_write(CSR_ADDR_NDMA_SIZE, 32'h0);
        csr_write(CSR_ADDR_NDMA_CTRL, 32'h3);
        checks++;
        if (vld !== 1'b0) begin errors++; $display("[TB] FAIL zero_size_vld got %b expected 0", vld); end
        csr_read(CSR_ADDR_NDMA_STATUS, d);
        checks++;
        if (d !== 32'h2) begin errors++; $display("[TB] FAIL zero_size_err got %h expected 2", d); end
        csr_read(CSR_ADDR_NDMA_CTRL, d);
        checks++;
        if (d !== 32'h3) begin errors++; $display("[TB] FAIL ctrl_last got %h expected 3", d); end
        csr_write(CSR_ADDR_NDMA_STATUS, 32'h2);
        csr_read(CSR_ADDR_NDMA_STATUS, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("[TB] FAIL err_clear2 got %h expected 0", d); end
    endtask

    task automatic test_counters();
        logic [31:0] d;
        done      = 1'b1;
        done_type = 2'd2;
        csr_write(CSR_ADDR_NDMA_RD_DONE, 32'h10);
        done      = 1'b0;
        done_type = 2'd0;
        csr_read(CSR_ADDR_NDMA_RD_DONE, d);
        checks++;
        if (d !== 32'h11) begin errors++; $display("[TB] FAIL load_plus_inc got %h expected 11", d); end
        csr_write(CSR_ADDR_NDMA_RD_DONE, 32'hFFFF);
        done_pulse(2'd2);
        csr_read(CSR_ADDR_NDMA_RD_DONE, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("[TB] FAIL cnt_wrap got %h expected 0", d); end
        done_pulse(2'd0);
        csr_read(CSR_ADDR_NDMA_WR_DONE, d);
        checks++;
        if (d !== 32'h1) begin errors++; $display("[TB] FAIL type0_wr got %h expected 1", d); end
        csr_read(CSR_ADDR_NDMA_SWAP_DONE, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("[TB] FAIL type0_swap got %h expected 0", d); end
        done_pulse(2'd3);
        csr_read(CSR_ADDR_NDMA_SWAP_DONE, d);
        checks++;
        if (d !== 32'h1) begin errors++; $display("[TB] FAIL swap_cnt got %h expected 1", d); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        rdy = 1'b0;
        csr_write(CSR_ADDR_NDMA_SIZE, 32'h40);
        csr_write(CSR_ADDR_NDMA_CTRL, 32'h1);
        checks++;
        if (vld !== 1'b1) begin errors++; $display("[TB] FAIL mid_vld_pre got %b expected 1", vld); end
        #2;
        rst_i = 1'b0;
        #1;
        checks++;
        if (vld !== 1'b0) begin errors++; $display("[TB] FAIL mid_vld_rst got %b expected 0", vld); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("[TB] FAIL mid_irq_rst got %b expected 0", irq); end
        tick();
        rst_i = 1'b1;
        tick();
        foreach (all_addrs[i]) begin
            csr_read(all_addrs[i], d);
            checks++;
            if (d !== 32'h0) begin errors++; $display("[TB] FAIL post_rst_csr[%h] got %h expected 0", all_addrs[i], d); end
        end
        checks++;
        if (vld !== 1'b0) begin errors++; $display("[TB] FAIL post_rst_vld got %b expected 0", vld); end
    endtask

    initial begin
        test_reset();
        test_read_latency();
        test_cmd_launch();
        test_completion();
        test_reject();
        test_counters();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
